// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the MEM stage and a byte-wide
// data memory. A 8/16/32-bit request is split into sequential byte accesses,
// most significant byte first, and load data is reassembled big-endian.
// Optional feature macro: MISALIGN_TRAP_EN (reject misaligned half/word).
module mem_access_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [7:0]  mem_address,
   output logic [7:0]  mem_write_data,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [7:0]  mem_read_data
);

   typedef enum logic [1:0] {IDLE, XFER, CAPT, DONE} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [1:0]  last_cnt;
   logic        write_q;
   logic        signed_q;
   logic [1:0]  size_q;
   logic [31:0] wdata_q;
   logic [31:0] acc;

   logic        reject;
   logic [1:0]  req_last;
   logic [1:0]  next_cnt;
   logic [31:0] acc_shift;
   logic [31:0] load_result;

   // Byte i of a word, where byte 0 is the least significant.
   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   // Index of the final byte (n-1) for a given size code.
   function automatic logic [1:0] size_to_last(input logic [1:0] s);
      case (s)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   assign req_ready = (state == IDLE);
   assign req_last  = size_to_last(req_size);
   assign next_cnt  = cnt + 2'd1;
   assign acc_shift = {acc[23:0], mem_read_data};

   // Decide whether an incoming request is refused without touching memory.
   always_comb begin
      reject = (req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
      if (req_size == 2'b01 && req_addr[0])
         reject = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
         reject = 1'b1;
`endif
   end

   // Final load value: sign-extend signed byte/half loads, otherwise zero-extend.
   always_comb begin
      load_result = acc_shift;
      if (signed_q && size_q == 2'b00)
         load_result = {{24{acc_shift[7]}}, acc_shift[7:0]};
      else if (signed_q && size_q == 2'b01)
         load_result = {{16{acc_shift[15]}}, acc_shift[15:0]};
   end

   // Sequencer: all memory-port and response outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= 2'd0;
         last_cnt       <= 2'd0;
         write_q        <= 1'b0;
         signed_q       <= 1'b0;
         size_q         <= 2'b00;
         wdata_q        <= 32'h0;
         acc            <= 32'h0;
         resp_valid     <= 1'b0;
         resp_err       <= 1'b0;
         resp_rdata     <= 32'h0;
         mem_address    <= 8'h00;
         mem_write_data <= 8'h00;
         MemWrite       <= 1'b0;
         MemRead        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               if (req_valid) begin
                  write_q  <= req_write;
                  signed_q <= req_signed;
                  size_q   <= req_size;
                  wdata_q  <= req_wdata;
                  last_cnt <= req_last;
                  cnt      <= 2'd0;
                  acc      <= 32'h0;
                  if (reject) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state          <= XFER;
                     mem_address    <= req_addr;
                     MemWrite       <= req_write;
                     MemRead        <= !req_write;
                     mem_write_data <= req_write ? pick_byte(req_wdata, req_last) : 8'h00;
                  end
               end
            end
            XFER: begin
               if (!write_q && cnt != 2'd0)
                  acc <= acc_shift;
               if (cnt != last_cnt) begin
                  cnt            <= next_cnt;
                  mem_address    <= mem_address + 8'd1;
                  mem_write_data <= write_q ? pick_byte(wdata_q, last_cnt - next_cnt) : 8'h00;
               end else begin
                  mem_address    <= 8'h00;
                  mem_write_data <= 8'h00;
                  MemWrite       <= 1'b0;
                  MemRead        <= 1'b0;
                  if (write_q) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                  end else begin
                     state <= CAPT;
                  end
               end
            end
            CAPT: begin
               acc        <= acc_shift;
               resp_rdata <= load_result;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               state      <= DONE;
            end
            default: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl with a synchronous byte-wide memory model.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [7:0]  mem_address;
   logic [7:0]  mem_write_data;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  mem_read_data;

   logic [7:0]  mem [256];

   int n_checks;
   int n_fail;

   mem_access_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_err       (resp_err),
      .resp_rdata     (resp_rdata),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .MemWrite       (MemWrite),
      .MemRead        (MemRead),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: write on the edge, read data valid the cycle after MemRead.
   always @(posedge clk) begin
      if (MemWrite)
         mem[mem_address] <= mem_write_data;
      if (MemRead)
         mem_read_data <= mem[mem_address];
   end

   // Present a request at the current negedge; return at the negedge of T+1.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [7:0] ad, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = ad;
      req_wdata  = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // From T+1, count cycles until resp_valid (bounded); T+1 counts as 1.
   task automatic wait_resp(output int cycles);
      cycles = 1;
      while (!resp_valid && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      logic [52:0] obs;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      obs = {resp_valid, resp_err, MemRead, MemWrite, mem_address, mem_write_data, resp_rdata, 1'b0};
      n_checks++;
      if (obs !== 53'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs got %h expected 0", obs);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_ready got %b expected 1", req_ready);
      end
   endtask

   task automatic test_store_word();
      logic [19:0] obs, exp;
      logic [31:0] wd;
      wd = 32'h11223344;
      issue(1'b1, 2'b10, 1'b0, 8'h10, wd);
      for (int k = 0; k < 4; k++) begin
         obs = {MemWrite, MemRead, mem_address, mem_write_data, resp_valid, req_ready};
         exp = {1'b1, 1'b0, 8'h10 + 8'(k), wd[(3-k)*8 +: 8], 1'b0, 1'b0};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL store_word_cycle%0d got %h expected %h", k, obs, exp);
         end
         @(negedge clk);
      end
      obs = {MemWrite, MemRead, mem_address, mem_write_data, resp_valid, resp_err};
      exp = {2'b00, 16'h0000, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL store_word_resp got %h expected %h", obs, exp);
      end
      @(negedge clk);
      n_checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL store_word_idle got %b expected 01", {resp_valid, req_ready});
      end
      n_checks++;
      if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== wd) begin
         n_fail++;
         $display("[TB] FAIL store_word_memory got %h expected %h",
                  {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, wd);
      end
   endtask

   task automatic test_load_word();
      logic [11:0] obs, exp;
      issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
      for (int k = 0; k < 4; k++) begin
         obs = {MemRead, MemWrite, mem_address, resp_valid, req_ready};
         exp = {1'b1, 1'b0, 8'h10 + 8'(k), 1'b0, 1'b0};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL load_word_cycle%0d got %h expected %h", k, obs, exp);
         end
         @(negedge clk);
      end
      n_checks++;
      if ({MemRead, MemWrite, resp_valid} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL load_word_capt got %b expected 000", {MemRead, MemWrite, resp_valid});
      end
      @(negedge clk);
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h11223344}) begin
         n_fail++;
         $display("[TB] FAIL load_word_resp got %b %b %h expected 1 0 11223344",
                  resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_sign_ext();
      int cyc;
      issue(1'b1, 2'b00, 1'b0, 8'h20, 32'h00000080);
      wait_resp(cyc);
      n_checks++;
      if (cyc != 2 || resp_err !== 1'b0 || resp_rdata !== 32'h11223344) begin
         n_fail++;
         $display("[TB] FAIL store_byte got cyc=%0d err=%b rdata=%h expected 2 0 11223344",
                  cyc, resp_err, resp_rdata);
      end
      @(negedge clk);
      issue(1'b0, 2'b00, 1'b1, 8'h20, 32'h0);
      wait_resp(cyc);
      n_checks++;
      if (cyc != 3 || resp_rdata !== 32'hFFFFFF80) begin
         n_fail++;
         $display("[TB] FAIL load_byte_signed got cyc=%0d rdata=%h expected 3 FFFFFF80", cyc, resp_rdata);
      end
      @(negedge clk);
      issue(1'b0, 2'b00, 1'b0, 8'h20, 32'h0);
      wait_resp(cyc);
      n_checks++;
      if (cyc != 3 || resp_rdata !== 32'h00000080) begin
         n_fail++;
         $display("[TB] FAIL load_byte_unsigned got cyc=%0d rdata=%h expected 3 00000080", cyc, resp_rdata);
      end
      @(negedge clk);
      issue(1'b1, 2'b01, 1'b0, 8'h30, 32'h00008001);
      wait_resp(cyc);
      n_checks++;
      if (cyc != 3 || {mem[8'h30], mem[8'h31]} !== 16'h8001) begin
         n_fail++;
         $display("[TB] FAIL store_half got cyc=%0d mem=%h expected 3 8001", cyc, {mem[8'h30], mem[8'h31]});
      end
      @(negedge clk);
      issue(1'b0, 2'b01, 1'b1, 8'h30, 32'h0);
      wait_resp(cyc);
      n_checks++;
      if (cyc != 4 || resp_rdata !== 32'hFFFF8001) begin
         n_fail++;
         $display("[TB] FAIL load_half_signed got cyc=%0d rdata=%h expected 4 FFFF8001", cyc, resp_rdata);
      end
      @(negedge clk);
      issue(1'b0, 2'b11, 1'b0, 8'h30, 32'h0);
      n_checks++;
      if ({resp_valid, resp_err, MemRead, MemWrite} !== 4'b1100 || resp_rdata !== 32'hFFFF8001) begin
         n_fail++;
         $display("[TB] FAIL reserved_size got %b rdata=%h expected 1100 FFFF8001",
                  {resp_valid, resp_err, MemRead, MemWrite}, resp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
      issue(1'b0, 2'b10, 1'b0, 8'hFE, 32'h0);
      n_checks++;
      if ({resp_valid, resp_err, MemRead, MemWrite} !== 4'b1100) begin
         n_fail++;
         $display("[TB] FAIL misalign_word_trap got %b expected 1100", {resp_valid, resp_err, MemRead, MemWrite});
      end
      @(negedge clk);
      n_checks++;
      if ({req_ready, resp_valid, MemRead} !== 3'b100) begin
         n_fail++;
         $display("[TB] FAIL misalign_word_after got %b expected 100", {req_ready, resp_valid, MemRead});
      end
      issue(1'b1, 2'b01, 1'b0, 8'h21, 32'h0000BEEF);
      n_checks++;
      if ({resp_valid, resp_err, MemRead, MemWrite} !== 4'b1100) begin
         n_fail++;
         $display("[TB] FAIL misalign_half_trap got %b expected 1100", {resp_valid, resp_err, MemRead, MemWrite});
      end
      @(negedge clk);
`else
      int cyc;
      logic [7:0] exp_addr [4];
      exp_addr[0] = 8'hFE;
      exp_addr[1] = 8'hFF;
      exp_addr[2] = 8'h00;
      exp_addr[3] = 8'h01;
      issue(1'b1, 2'b10, 1'b0, 8'hFE, 32'hA1B2C3D4);
      wait_resp(cyc);
      n_checks++;
      if (cyc != 5 || resp_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL misalign_store got cyc=%0d err=%b expected 5 0", cyc, resp_err);
      end
      @(negedge clk);
      issue(1'b0, 2'b10, 1'b0, 8'hFE, 32'h0);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({MemRead, mem_address} !== {1'b1, exp_addr[k]}) begin
            n_fail++;
            $display("[TB] FAIL misalign_addr%0d got %b %h expected 1 %h", k, MemRead, mem_address, exp_addr[k]);
         end
         @(negedge clk);
      end
      @(negedge clk);
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'hA1B2C3D4}) begin
         n_fail++;
         $display("[TB] FAIL misalign_load got %b %b %h expected 1 0 A1B2C3D4", resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
`endif
   endtask

   task automatic test_reset_mid_store();
      int cyc;
      logic [52:0] obs;
      issue(1'b1, 2'b10, 1'b0, 8'h40, 32'hDEADBEEF);
      @(negedge clk);
      n_checks++;
      if (MemWrite !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midstore_active got %b expected 1", MemWrite);
      end
      #2 rst_n = 1'b0;
      #1;
      obs = {resp_valid, resp_err, MemRead, MemWrite, mem_address, mem_write_data, resp_rdata, 1'b0};
      n_checks++;
      if (obs !== 53'h0) begin
         n_fail++;
         $display("[TB] FAIL midstore_reset_outputs got %h expected 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if (mem[8'h40] !== 8'hDE || mem[8'h41] === 8'hAD) begin
         n_fail++;
         $display("[TB] FAIL midstore_memory got %h %h expected DE and not AD", mem[8'h40], mem[8'h41]);
      end
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midstore_ready got %b expected 1", req_ready);
      end
      issue(1'b1, 2'b00, 1'b0, 8'h60, 32'h0000005A);
      wait_resp(cyc);
      n_checks++;
      if (cyc != 2 || resp_err !== 1'b0 || mem[8'h60] !== 8'h5A) begin
         n_fail++;
         $display("[TB] FAIL midstore_next got cyc=%0d err=%b mem=%h expected 2 0 5A", cyc, resp_err, mem[8'h60]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc, accepts, resps, both, last_cyc;
      logic prev_write;
      logic [7:0] stored;
      accepts = 0; resps = 0; both = 0; last_cyc = 0; prev_write = 1'b0; stored = 8'h00; cyc = 0;
      req_valid  = 1'b1;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 8'h50;
      while (cyc < 200 && accepts < 8) begin
         if (MemRead && MemWrite) both++;
         if (resp_valid) begin
            resps++;
            if (!prev_write) begin
               n_checks++;
               if (resp_rdata !== {24'h0, stored}) begin
                  n_fail++;
                  $display("[TB] FAIL b2b_load_data got %h expected %h", resp_rdata, {24'h0, stored});
               end
            end
         end
         if (req_ready) begin
            if (accepts > 0) begin
               n_checks++;
               if (cyc - last_cyc != (prev_write ? 3 : 4)) begin
                  n_fail++;
                  $display("[TB] FAIL b2b_gap%0d got %0d expected %0d", accepts, cyc - last_cyc, prev_write ? 3 : 4);
               end
            end
            req_write = (accepts % 2 == 0);
            req_wdata = {24'h0, 8'h70 + 8'(accepts)};
            if (req_write) stored = 8'h70 + 8'(accepts);
            prev_write = req_write;
            last_cyc = cyc;
            accepts++;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      repeat (6) begin
         if (MemRead && MemWrite) both++;
         if (resp_valid) resps++;
         @(negedge clk);
      end
      n_checks++;
      if (resps != 8 || both != 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_totals got resps=%0d both=%0d expected 8 0", resps, both);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_size = 2'b00;
      req_signed = 1'b0;
      req_addr = 8'h00;
      req_wdata = 32'h0;
      test_reset();
      test_store_word();
      test_load_word();
      test_sign_ext();
      test_misalign();
      test_reset_mid_store();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
